dbg_host_bridge: RTL

Byte-stream-to-debug-port bridge that acts as the initiator side of the core debug port (cmd/addr/data/ready).
- Assembles fixed 9-byte command frames from a UART-style byte receiver.
- Drives the debug command handshake into the debug module.
- Returns read data and a status byte on a valid/ready byte transmitter.
- Sits between the board-level UART and the core wrapper's dbg_* inputs, so the host PC can load and inspect memory and reset the core.

---
 rtl/dbg_host_pkg.sv | 16 +
 rtl/dbg_frame_rx.sv | 59 +++++
 rtl/dbg_host_bridge.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dbg_host_pkg.sv
// Shared types and constants for the host byte-stream to debug-port bridge.
package dbg_host_pkg;

  typedef enum logic [1:0] {
    RECV = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int         FRAME_LEN   = 9;
  localparam logic [7:0] CMD_NOP     = 8'h00;
  localparam int         READ_BIT    = 7;
  localparam logic [7:0] ACK_DEFAULT = 8'hAC;
  localparam logic [7:0] NAK_DEFAULT = 8'hEE;

endpackage

// File: rtl/dbg_frame_rx.sv
// Collects 9-byte host frames (cmd, addr LE, data LE) and drops partial
// frames left idle for too long.
module dbg_frame_rx
  import dbg_host_pkg::*;
#(
  parameter int FRAME_TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic        accept_en,
  output logic        frame_valid,
  output logic [7:0]  cmd,
  output logic [31:0] addr,
  output logic [31:0] data
);

  localparam int            TW       = $clog2(FRAME_TIMEOUT) + 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(FRAME_TIMEOUT - 1);

  logic [3:0]    byte_cnt;
  logic [TW-1:0] idle_tmr;
  logic [7:0]    frame_q [0:FRAME_LEN-2];
  logic          take;

  assign take        = accept_en && rx_valid_i;
  assign frame_valid = take && (byte_cnt == 4'(FRAME_LEN - 1));

  // The last byte is used straight from the receiver so the frame is
  // available in the same cycle it completes.
  assign cmd  = frame_q[0];
  assign addr = {frame_q[4], frame_q[3], frame_q[2], frame_q[1]};
  assign data = {rx_data_i, frame_q[7], frame_q[6], frame_q[5]};

  always_ff @(posedge clk) begin
    if (rst_i) begin
      byte_cnt <= '0;
      idle_tmr <= '0;
      frame_q  <= '{default: '0};
    end else if (take) begin
      idle_tmr <= TMR_LOAD;
      if (frame_valid) begin
        byte_cnt <= '0;
      end else begin
        frame_q[byte_cnt[2:0]] <= rx_data_i;
        byte_cnt               <= byte_cnt + 4'd1;
      end
    end else if (byte_cnt != '0) begin
      // Down-counter terminal count discards the partial frame.
      if (idle_tmr == '0) begin
        byte_cnt <= '0;
      end else begin
        idle_tmr <= idle_tmr - TW'(1);
      end
    end
  end

endmodule

// File: rtl/dbg_host_bridge.sv
// Host frame to debug-port initiator: runs one debug command per frame and
// returns read data plus a status byte on the byte transmitter.
//
//   state | meaning
//   RECV  | collecting frame bytes, debug port idle
//   EXEC  | command driven, waiting for dbg_ready_i or wait timeout
//   RESP  | shifting response bytes out, debug port idle (NOP gap)
module dbg_host_bridge
  import dbg_host_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter int         FRAME_TIMEOUT  = 100000,
  parameter logic [7:0] ACK_BYTE       = ACK_DEFAULT,
  parameter logic [7:0] NAK_BYTE       = NAK_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [7:0]  dbg_cmd_o,
  output logic [31:0] dbg_addr_o,
  output logic [31:0] dbg_data_o,
  input  logic [31:0] dbg_data_i,
  input  logic        dbg_ready_i,
  output logic        busy_o,
  output logic        overrun_o,
  output logic        timeout_o
);

  localparam int            WW        = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WW-1:0] WAIT_LOAD = WW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [WW-1:0] wait_tmr;
  logic          exec_first;
  logic [2:0]    resp_left;
  logic [31:0]   resp_sh;
  logic          frame_valid;
  logic [7:0]    f_cmd;
  logic [31:0]   f_addr;
  logic [31:0]   f_data;

  dbg_frame_rx #(
    .FRAME_TIMEOUT(FRAME_TIMEOUT)
  ) u_frame_rx (
    .clk        (clk),
    .rst_i      (rst_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .accept_en  (state == RECV),
    .frame_valid(frame_valid),
    .cmd        (f_cmd),
    .addr       (f_addr),
    .data       (f_data)
  );

  assign busy_o = (state != RECV);

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state      <= RECV;
      wait_tmr   <= '0;
      exec_first <= 1'b0;
      resp_left  <= '0;
      resp_sh    <= '0;
      tx_data_o  <= '0;
      tx_valid_o <= 1'b0;
      dbg_cmd_o  <= CMD_NOP;
      dbg_addr_o <= '0;
      dbg_data_o <= '0;
      overrun_o  <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      if (rx_valid_i && (state != RECV)) overrun_o <= 1'b1;

      case (state)
        RECV: begin
          if (frame_valid) begin
            if (f_cmd == CMD_NOP) begin
              tx_data_o  <= ACK_BYTE;
              tx_valid_o <= 1'b1;
              resp_left  <= '0;
              state      <= RESP;
            end else begin
              dbg_cmd_o  <= f_cmd;
              dbg_addr_o <= f_addr;
              dbg_data_o <= f_data;
              wait_tmr   <= WAIT_LOAD;
              exec_first <= 1'b1;
              state      <= EXEC;
            end
          end
        end

        EXEC: begin
          exec_first <= 1'b0;
          // Ready seen in the first cycle may be left over from the previous command.
          if (!exec_first && dbg_ready_i) begin
            dbg_cmd_o  <= CMD_NOP;
            tx_valid_o <= 1'b1;
            state      <= RESP;
            if (dbg_cmd_o[READ_BIT]) begin
              tx_data_o <= dbg_data_i[7:0];
              resp_sh   <= {ACK_BYTE, dbg_data_i[31:8]};
              resp_left <= 3'd4;
            end else begin
              tx_data_o <= ACK_BYTE;
              resp_left <= '0;
            end
          end else if (wait_tmr == '0) begin
            dbg_cmd_o  <= CMD_NOP;
            timeout_o  <= 1'b1;
            tx_data_o  <= NAK_BYTE;
            tx_valid_o <= 1'b1;
            resp_left  <= '0;
            state      <= RESP;
          end else begin
            wait_tmr <= wait_tmr - WW'(1);
          end
        end

        RESP: begin
          if (tx_ready_i) begin
            if (resp_left == '0) begin
              tx_valid_o <= 1'b0;
              state      <= RECV;
            end else begin
              tx_data_o <= resp_sh[7:0];
              resp_sh   <= {8'h00, resp_sh[31:8]};
              resp_left <= resp_left - 3'd1;
            end
          end
        end

        default: state <= RECV;
      endcase
    end
  end

endmodule
